lsu_mem_stage: RTL and testbench

- Load/store unit directly downstream of the single-cycle core's ALU/register-file datapath.
- Consumes the ALU result (address), RD2 (store data) and funct3 for load/store instructions; drives a word-wide data-memory bus with a req/ack handshake.
- Returns a sign- or zero-extended load result for the register write-back mux.
- Stalls the core (PC hold) while a bus access is outstanding; splits word-boundary-crossing accesses into two bus transactions.

---
 rtl/lsu_mem_stage.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_lsu_mem_stage.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage.sv
// ---------------------------------------------------------------------------
// lsu_mem_stage
//   Load/store unit placed after the ALU / register-file datapath of a
//   single-cycle core. Takes the ALU result as a byte address, RD2 as store
//   data and funct3 as the access size/sign. It drives a word-wide data bus
//   with a req/ack handshake and returns an extended load result for the
//   write-back mux. The core PC is held (stall) while an access is in flight.
//   Accesses that cross a word boundary are split into two word transactions
//   (or rejected with access_err when SUPPORT_MISALIGNED = 0).
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   req_valid    core presents a load/store this cycle
//   req_write    1 = store, 0 = load
//   req_funct3   RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   req_addr     byte address
//   req_wdata    store data
//   stall        core must hold PC and request inputs
//   rdata        extended load result (held between loads)
//   rdata_valid  one-cycle pulse, rdata valid for write-back
//   access_err   one-cycle pulse on illegal funct3 / rejected misalignment
//   mem_req      bus request
//   mem_we       bus write
//   mem_addr     word-aligned bus address
//   mem_be       byte enables
//   mem_wdata    lane-aligned write data
//   mem_ack      bus completion, only meaningful while mem_req = 1
//   mem_rdata    bus read data, valid with mem_ack
// ---------------------------------------------------------------------------
module lsu_mem_stage #(
  parameter bit SUPPORT_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        access_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    DONE = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // Decode helpers
  // -------------------------------------------------------------------------

  // Access size in bytes from funct3[1:0]; the 11 encoding is illegal anyway.
  function automatic logic [2:0] f_size(input logic [1:0] sz);
    logic [2:0] res;
    case (sz)
      2'b00:   res = 3'd1;
      2'b01:   res = 3'd2;
      default: res = 3'd4;
    endcase
    return res;
  endfunction

  function automatic logic f_illegal(input logic wr, input logic [2:0] f3);
    logic res;
    if (wr) begin
      res = (f3 > 3'b010);
    end else begin
      case (f3)
        3'b011, 3'b110, 3'b111: res = 1'b1;
        default:                res = 1'b0;
      endcase
    end
    return res;
  endfunction

  // Crosses into the next word when offset + size exceeds 4 bytes.
  function automatic logic f_split(input logic [1:0] off, input logic [1:0] sz);
    return (({1'b0, off} + f_size(sz)) > 3'd4);
  endfunction

  // 8-bit enable mask spanning both words: [3:0] first word, [7:4] second.
  function automatic logic [7:0] f_mask(input logic [1:0] off, input logic [1:0] sz);
    logic [7:0] base;
    case (sz)
      2'b00:   base = 8'b0000_0001;
      2'b01:   base = 8'b0000_0011;
      default: base = 8'b0000_1111;
    endcase
    return base << off;
  endfunction

  // Store data truncated to its size, then moved onto its byte lanes.
  function automatic logic [63:0] f_shift(input logic [31:0] wd, input logic [1:0] off,
                                          input logic [1:0] sz);
    logic [31:0] trunc;
    case (sz)
      2'b00:   trunc = {24'd0, wd[7:0]};
      2'b01:   trunc = {16'd0, wd[15:0]};
      default: trunc = wd;
    endcase
    return {32'd0, trunc} << {off, 3'b000};
  endfunction

  // Realign the (possibly two-word) read data and sign/zero-extend it.
  function automatic logic [31:0] f_load(input logic [31:0] lo, input logic [31:0] hi,
                                         input logic [1:0] off, input logic [2:0] f3);
    logic [31:0] w;
    logic [31:0] res;
    w = 32'({hi, lo} >> {off, 3'b000});
    case (f3)
      3'b000:  res = {{24{w[7]}}, w[7:0]};
      3'b001:  res = {{16{w[15]}}, w[15:0]};
      3'b100:  res = {24'd0, w[7:0]};
      3'b101:  res = {16'd0, w[15:0]};
      default: res = w;
    endcase
    return res;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        write_q, write_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rdata_valid_q, rdata_valid_d;
  logic        access_err_q, access_err_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  // Decode of the incoming request (used in IDLE) and of the latched one.
  logic        in_split_s;
  logic        in_illegal_s;
  logic [7:0]  in_mask_s;
  logic [63:0] in_shift_s;
  logic        q_split_s;
  logic [7:0]  q_mask_s;
  logic [63:0] q_shift_s;

  assign in_split_s   = f_split(req_addr[1:0], req_funct3[1:0]);
  assign in_illegal_s = f_illegal(req_write, req_funct3);
  assign in_mask_s    = f_mask(req_addr[1:0], req_funct3[1:0]);
  assign in_shift_s   = f_shift(req_wdata, req_addr[1:0], req_funct3[1:0]);
  assign q_split_s    = f_split(addr_q[1:0], funct3_q[1:0]);
  assign q_mask_s     = f_mask(addr_q[1:0], funct3_q[1:0]);
  assign q_shift_s    = f_shift(wdata_q, addr_q[1:0], funct3_q[1:0]);

  // Next-state and registered-output logic of the access sequencer.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    funct3_d      = funct3_q;
    write_d       = write_q;
    wdata_d       = wdata_q;
    lo_d          = lo_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    access_err_d  = 1'b0;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_be_d      = mem_be_q;
    mem_wdata_d   = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          funct3_d = req_funct3;
          write_d  = req_write;
          wdata_d  = req_wdata;
          if (in_illegal_s || (!SUPPORT_MISALIGNED && in_split_s)) begin
            // Rejected: go straight to DONE without touching the bus.
            state_d      = DONE;
            access_err_d = 1'b1;
          end else begin
            state_d     = ACC0;
            mem_req_d   = 1'b1;
            mem_we_d    = req_write;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_be_d    = in_mask_s[3:0];
            mem_wdata_d = in_shift_s[31:0];
          end
        end else begin
          state_d = IDLE;
        end
      end

      ACC0: begin
        if (mem_ack) begin
          lo_d = mem_rdata;
          if (q_split_s) begin
            state_d     = ACC1;
            // Natural 32-bit wrap takes 0xFFFFFFFC to 0x00000000.
            mem_addr_d  = {addr_q[31:2], 2'b00} + 32'd4;
            mem_be_d    = q_mask_s[7:4];
            mem_wdata_d = q_shift_s[63:32];
          end else begin
            state_d   = DONE;
            mem_req_d = 1'b0;
            if (!write_q) begin
              rdata_valid_d = 1'b1;
              rdata_d       = f_load(mem_rdata, 32'd0, addr_q[1:0], funct3_q);
            end else begin
              rdata_valid_d = 1'b0;
            end
          end
        end else begin
          state_d = ACC0;
        end
      end

      ACC1: begin
        if (mem_ack) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          if (!write_q) begin
            rdata_valid_d = 1'b1;
            rdata_d       = f_load(lo_q, mem_rdata, addr_q[1:0], funct3_q);
          end else begin
            rdata_valid_d = 1'b0;
          end
        end else begin
          state_d = ACC1;
        end
      end

      DONE: begin
        // The same instruction is still presented here; ignore req_valid.
        state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      addr_q        <= 32'd0;
      funct3_q      <= 3'd0;
      write_q       <= 1'b0;
      wdata_q       <= 32'd0;
      lo_q          <= 32'd0;
      rdata_q       <= 32'd0;
      rdata_valid_q <= 1'b0;
      access_err_q  <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= 32'd0;
      mem_be_q      <= 4'd0;
      mem_wdata_q   <= 32'd0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      funct3_q      <= funct3_d;
      write_q       <= write_d;
      wdata_q       <= wdata_d;
      lo_q          <= lo_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      access_err_q  <= access_err_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_be_q      <= mem_be_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  // Stall must rise in the request cycle itself, so it is combinational.
  assign stall = ((state_q == IDLE) && req_valid) || (state_q == ACC0) || (state_q == ACC1);

  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign access_err  = access_err_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_be      = mem_be_q;
  assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_stage
//   Directed bench for lsu_mem_stage. Instance a splits misaligned accesses,
//   instance b rejects them; sel chooses which instance receives requests
//   and whose outputs are observed. Expected bus beats and load results are
//   queued when a request is issued and popped as the bus model / write-back
//   observes them.
// ---------------------------------------------------------------------------
module tb_lsu_mem_stage;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } bus_t;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic        a_valid, b_valid;
  logic        a_stall, b_stall;
  logic [31:0] a_rdata, b_rdata;
  logic        a_rv, b_rv;
  logic        a_err, b_err;
  logic        a_req, b_req;
  logic        a_we, b_we;
  logic [31:0] a_addr, b_addr;
  logic [3:0]  a_be, b_be;
  logic [31:0] a_wd, b_wd;

  logic        o_stall, o_rv, o_err, o_req, o_we;
  logic [31:0] o_rdata, o_addr, o_wd;
  logic [3:0]  o_be;

  assign a_valid = req_valid & ~sel;
  assign b_valid = req_valid & sel;

  assign o_stall = sel ? b_stall : a_stall;
  assign o_rdata = sel ? b_rdata : a_rdata;
  assign o_rv    = sel ? b_rv    : a_rv;
  assign o_err   = sel ? b_err   : a_err;
  assign o_req   = sel ? b_req   : a_req;
  assign o_we    = sel ? b_we    : a_we;
  assign o_addr  = sel ? b_addr  : a_addr;
  assign o_be    = sel ? b_be    : a_be;
  assign o_wd    = sel ? b_wd    : a_wd;

  lsu_mem_stage #(.SUPPORT_MISALIGNED(1'b1)) dut_a (
    .clk(clk), .rst(rst), .req_valid(a_valid), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(a_stall), .rdata(a_rdata), .rdata_valid(a_rv), .access_err(a_err),
    .mem_req(a_req), .mem_we(a_we), .mem_addr(a_addr), .mem_be(a_be),
    .mem_wdata(a_wd), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  lsu_mem_stage #(.SUPPORT_MISALIGNED(1'b0)) dut_b (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(b_stall), .rdata(b_rdata), .rdata_valid(b_rv), .access_err(b_err),
    .mem_req(b_req), .mem_we(b_we), .mem_addr(b_addr), .mem_be(b_be),
    .mem_wdata(b_wd), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  int          total = 0;
  int          bad   = 0;
  bus_t        exp_bus[$];
  logic [31:0] exp_rd[$];
  logic [31:0] last_rd;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_bus(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd);
    bus_t b;
    b = {we, addr, be, wd};
    exp_bus.push_back(b);
  endtask

  // Issue one request and act as the bus: ack each beat after dly wait cycles.
  task automatic run_op(input string name, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] lo, input logic [31:0] hi,
                        input int dly, input int exp_stall, input logic exp_err);
    int          stall_cnt;
    int          wait_cnt;
    int          beat;
    bit          done;
    bit          exp_ld;
    bus_t        cur;
    bus_t        held;
    bus_t        e;
    logic [31:0] erd;
    exp_ld    = (exp_rd.size() > 0);
    stall_cnt = 0;
    wait_cnt  = 0;
    beat      = 0;
    done      = 1'b0;
    held      = '0;
    @(negedge clk);
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (cyc == 0) begin
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
      end else begin
        @(negedge clk);
      end
      mem_ack = 1'b0;
      if (o_req) begin
        cur = {o_we, o_addr, o_be, o_wd};
        if (wait_cnt == 0) begin
          if (exp_bus.size() == 0) begin
            check({name, "_unexpected_req"}, 128'd1, 128'd0);
            e = cur;
          end else begin
            e = exp_bus.pop_front();
          end
          held = e;
          check({name, "_bus"}, cur, e);
        end else begin
          check({name, "_hold"}, cur, held);
        end
        if (wait_cnt == dly) begin
          mem_ack   = 1'b1;
          mem_rdata = (beat == 0) ? lo : hi;
          beat++;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
      #1;
      if (o_stall) begin
        stall_cnt++;
        check({name, "_quiet"}, {o_rv, o_err}, 2'b00);
      end else begin
        done = 1'b1;
        check({name, "_stall_cycles"}, stall_cnt, exp_stall);
        check({name, "_pulses"}, {o_rv, o_err}, {exp_ld, exp_err});
        check({name, "_beats_left"}, exp_bus.size(), 0);
        if (exp_ld) begin
          erd = exp_rd.pop_front();
          last_rd = erd;
        end else begin
          erd = last_rd;
        end
        check({name, "_rdata"}, o_rdata, erd);
      end
    end
    if (!done) begin
      check({name, "_timeout"}, 128'd0, 128'd1);
      exp_bus.delete();
      exp_rd.delete();
    end
    @(negedge clk);
    req_valid = 1'b0;
    mem_ack   = 1'b0;
    #1;
    check({name, "_after"}, {o_stall, o_rv, o_err, o_req}, 4'b0000);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b0;
    sel        = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    mem_ack    = 1'b0;
    mem_rdata  = 32'd0;
    last_rd    = 32'd0;
    #2;
    check("reset_a", {a_stall, a_req, a_we, a_addr, a_be, a_wd, a_rdata, a_rv, a_err}, 128'd0);
    check("reset_b", {b_stall, b_req, b_we, b_addr, b_be, b_wd, b_rdata, b_rv, b_err}, 128'd0);
    @(negedge clk);
    rst = 1'b1;

    // Aligned store, ack in the first bus cycle.
    push_bus(1'b1, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF);
    run_op("sw_aligned", 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'd0, 32'd0, 0, 2, 1'b0);

    // Byte loads from lane 3, signed and unsigned.
    push_bus(1'b0, 32'h0000_0200, 4'b1000, 32'd0);
    exp_rd.push_back(32'hFFFF_FF80);
    run_op("lb", 1'b0, 3'b000, 32'h0000_0203, 32'd0, 32'h8011_2233, 32'd0, 0, 2, 1'b0);
    push_bus(1'b0, 32'h0000_0200, 4'b1000, 32'd0);
    exp_rd.push_back(32'h0000_0080);
    run_op("lbu", 1'b0, 3'b100, 32'h0000_0203, 32'd0, 32'h8011_2233, 32'd0, 0, 2, 1'b0);

    // Split word store and matching split word load.
    push_bus(1'b1, 32'h0000_0100, 4'b1110, 32'hBBCC_DD00);
    push_bus(1'b1, 32'h0000_0104, 4'b0001, 32'h0000_00AA);
    run_op("sw_split", 1'b1, 3'b010, 32'h0000_0101, 32'hAABB_CCDD, 32'd0, 32'd0, 0, 3, 1'b0);
    push_bus(1'b0, 32'h0000_0100, 4'b1110, 32'd0);
    push_bus(1'b0, 32'h0000_0104, 4'b0001, 32'd0);
    exp_rd.push_back(32'hAABB_CCDD);
    run_op("lw_split", 1'b0, 3'b010, 32'h0000_0101, 32'd0, 32'hBBCC_DD00, 32'h0000_00AA, 0, 3, 1'b0);

    // Halfword store in the upper lanes; data truncated to 16 bits.
    push_bus(1'b1, 32'h0000_0000, 4'b1100, 32'h5678_0000);
    run_op("sh_hi", 1'b1, 3'b001, 32'h0000_0002, 32'h1234_5678, 32'd0, 32'd0, 0, 2, 1'b0);

    // Misaligned halfword inside one word, zero-extended.
    push_bus(1'b0, 32'h0000_0000, 4'b0110, 32'd0);
    exp_rd.push_back(32'h0000_ABCD);
    run_op("lhu_mid", 1'b0, 3'b101, 32'h0000_0001, 32'd0, 32'h00AB_CD00, 32'd0, 0, 2, 1'b0);

    // Byte store: upper bits of RD2 must not reach the bus.
    push_bus(1'b1, 32'h0000_0000, 4'b0001, 32'h0000_00FE);
    run_op("sb_trunc", 1'b1, 3'b000, 32'h0000_0000, 32'h1234_56FE, 32'd0, 32'd0, 0, 2, 1'b0);

    // Split halfword load wrapping the address space.
    push_bus(1'b0, 32'hFFFF_FFFC, 4'b1000, 32'd0);
    push_bus(1'b0, 32'h0000_0000, 4'b0001, 32'd0);
    exp_rd.push_back(32'hFFFF_CDAB);
    run_op("lh_wrap", 1'b0, 3'b001, 32'hFFFF_FFFF, 32'd0, 32'hAB00_0000, 32'h0000_00CD, 0, 3, 1'b0);

    // Slow bus: five cycles without ack.
    push_bus(1'b0, 32'h0000_0400, 4'b1111, 32'd0);
    exp_rd.push_back(32'h0102_0304);
    run_op("lw_slow", 1'b0, 3'b010, 32'h0000_0400, 32'd0, 32'h0102_0304, 32'd0, 5, 7, 1'b0);

    // Slow split store, two wait cycles per beat.
    push_bus(1'b1, 32'h0000_0100, 4'b1000, 32'h4400_0000);
    push_bus(1'b1, 32'h0000_0104, 4'b0111, 32'h0011_2233);
    run_op("sw_split_slow", 1'b1, 3'b010, 32'h0000_0103, 32'h1122_3344, 32'd0, 32'd0, 2, 7, 1'b0);

    // Illegal funct3 encodings.
    run_op("ld_f3_011", 1'b0, 3'b011, 32'h0000_0010, 32'd0, 32'd0, 32'd0, 0, 1, 1'b1);
    run_op("ld_f3_110", 1'b0, 3'b110, 32'h0000_0010, 32'd0, 32'd0, 32'd0, 0, 1, 1'b1);
    run_op("st_f3_100", 1'b1, 3'b100, 32'h0000_0010, 32'h5555_5555, 32'd0, 32'd0, 0, 1, 1'b1);

    // Reset in the middle of a bus access.
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h0000_0300;
    mem_ack    = 1'b0;
    @(negedge clk);
    #1;
    check("rst_mid_req_up", o_req, 1'b1);
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_mid_outs", {o_stall, o_req, o_we, o_addr, o_be, o_wd, o_rdata, o_rv, o_err}, 128'd0);
    last_rd = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("rst_mid_quiet", {o_stall, o_rv, o_err, o_req}, 4'b0000);
    end

    // Instance that rejects boundary-crossing accesses.
    sel = 1'b1;
    run_op("nomis_lh_split", 1'b0, 3'b001, 32'h0000_0003, 32'd0, 32'd0, 32'd0, 0, 1, 1'b1);
    push_bus(1'b0, 32'h0000_0008, 4'b1111, 32'd0);
    exp_rd.push_back(32'hCAFE_F00D);
    run_op("nomis_lw", 1'b0, 3'b010, 32'h0000_0008, 32'd0, 32'hCAFE_F00D, 32'd0, 0, 2, 1'b0);
    push_bus(1'b0, 32'h0000_0000, 4'b0110, 32'd0);
    exp_rd.push_back(32'hFFFF_F000);
    run_op("nomis_lh_inword", 1'b0, 3'b001, 32'h0000_0001, 32'd0, 32'h00F0_0000, 32'd0, 0, 2, 1'b0);
    run_op("nomis_sw_split", 1'b1, 3'b010, 32'h0000_0102, 32'h0BAD_CAFE, 32'd0, 32'd0, 0, 1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
